// File: rtl/xctcmsg_pkg.sv
// Shared types and constants for the xctcmsg bus interconnect.
package xctcmsg_pkg;

    localparam int BUS_ADDR_W = 32;
    localparam int BUS_TAG_W  = 32;
    localparam int BUS_MSG_W  = 64;

    typedef struct packed {
        logic [BUS_ADDR_W-1:0] src;
        logic [BUS_TAG_W-1:0]  tag;
        logic [BUS_MSG_W-1:0]  msg;
    } bus_packet_t;

    // Index width for an n-entry port set; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/xctcmsg_bus_interconnect_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer,
// then moves the pointer one past the winner.
module rr_arbiter
    import xctcmsg_pkg::*;
#(
    parameter  int N     = 4,
    localparam int IDX_W = idx_w(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic             en,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_v
);

    logic [IDX_W-1:0] ptr_r;

    // Rotating priority search starting at the pointer.
    always_comb begin
        int  p;
        logic hit_s;
        grant     = '0;
        grant_idx = '0;
        grant_v   = 1'b0;
        p         = 0;
        hit_s     = 1'b0;
        for (int i = 0; i < N; i++) begin
            p         = (int'(ptr_r) + i) % N;
            hit_s     = en & ~grant_v & req[p];
            grant[p]  = hit_s;
            grant_idx = hit_s ? IDX_W'(p) : grant_idx;
            grant_v   = grant_v | hit_s;
        end
    end

    // Pointer advances past the winner, holds when nothing is granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= '0;
        end else if (grant_v) begin
            ptr_r <= (grant_idx == IDX_W'(N - 1)) ? '0 : grant_idx + IDX_W'(1);
        end else begin
            ptr_r <= ptr_r;
        end
    end

endmodule

// File: rtl/xctcmsg_bus_interconnect.sv
// Shared message bus: round-robin capture into a single holding register,
// delivery to the addressed port, drop counting for bad destinations.
module xctcmsg_bus_interconnect
    import xctcmsg_pkg::*;
#(
    parameter int N_PORTS    = 4,
    parameter int DROP_CNT_W = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_PORTS-1:0]        snd_val_i,
    output logic [N_PORTS-1:0]        snd_ack_o,
    input  logic [N_PORTS*32-1:0]     snd_dst_i,
    input  logic [N_PORTS*32-1:0]     snd_tag_i,
    input  logic [N_PORTS*64-1:0]     snd_msg_i,
    input  logic [N_PORTS-1:0]        rcv_rdy_i,
    output logic [N_PORTS-1:0]        rcv_val_o,
    output logic [31:0]               rcv_src_o,
    output logic [31:0]               rcv_tag_o,
    output logic [63:0]               rcv_msg_o,
    output logic [DROP_CNT_W-1:0]     drop_cnt_o
);

    localparam int IDX_W = idx_w(N_PORTS);

    logic                  hold_v_r;
    logic [IDX_W-1:0]      dst_idx_r;
    bus_packet_t           pkt_r;
    logic [DROP_CNT_W-1:0] drop_cnt_r;

    logic                  deliver_s;
    logic                  cap_en_s;
    logic [N_PORTS-1:0]    grant_s;
    logic [IDX_W-1:0]      grant_idx_s;
    logic                  grant_v_s;
    logic [BUS_ADDR_W-1:0] gnt_dst_s;
    logic                  in_range_s;
    logic                  capture_s;
    logic                  drop_s;

    assign deliver_s = hold_v_r & rcv_rdy_i[dst_idx_r];
    assign cap_en_s  = ~hold_v_r | deliver_s;

    rr_arbiter #(.N(N_PORTS)) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (snd_val_i),
        .en        (cap_en_s),
        .grant     (grant_s),
        .grant_idx (grant_idx_s),
        .grant_v   (grant_v_s)
    );

    assign gnt_dst_s  = snd_dst_i[BUS_ADDR_W*grant_idx_s +: BUS_ADDR_W];
    assign in_range_s = gnt_dst_s < BUS_ADDR_W'(N_PORTS);
    assign capture_s  = grant_v_s & in_range_s;
    assign drop_s     = grant_v_s & ~in_range_s;

    // Ack is the grant itself; forced low while reset is held so nothing is acked then.
    assign snd_ack_o  = rst_n ? grant_s : '0;

    // Only the addressed port sees valid.
    always_comb begin
        rcv_val_o            = '0;
        rcv_val_o[dst_idx_r] = hold_v_r;
    end

    assign rcv_src_o  = pkt_r.src;
    assign rcv_tag_o  = pkt_r.tag;
    assign rcv_msg_o  = pkt_r.msg;
    assign drop_cnt_o = drop_cnt_r;

    // Holding register: a capture wins over a same-cycle delivery, so no bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_v_r  <= 1'b0;
            dst_idx_r <= '0;
            pkt_r     <= '0;
        end else if (capture_s) begin
            hold_v_r  <= 1'b1;
            dst_idx_r <= gnt_dst_s[IDX_W-1:0];
            pkt_r     <= '{src: BUS_ADDR_W'(grant_idx_s),
                           tag: snd_tag_i[BUS_TAG_W*grant_idx_s +: BUS_TAG_W],
                           msg: snd_msg_i[BUS_MSG_W*grant_idx_s +: BUS_MSG_W]};
        end else if (deliver_s) begin
            hold_v_r  <= 1'b0;
            dst_idx_r <= dst_idx_r;
            pkt_r     <= pkt_r;
        end else begin
            hold_v_r  <= hold_v_r;
            dst_idx_r <= dst_idx_r;
            pkt_r     <= pkt_r;
        end
    end

    // Saturating count of messages dropped for out-of-range destinations.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_r <= '0;
        end else if (drop_s && (drop_cnt_r != {DROP_CNT_W{1'b1}})) begin
            drop_cnt_r <= drop_cnt_r + DROP_CNT_W'(1);
        end else begin
            drop_cnt_r <= drop_cnt_r;
        end
    end

endmodule

// File: tb/tb_xctcmsg_bus_interconnect.sv
// Directed bench for the bus interconnect with a per-cycle reference model.
module tb_xctcmsg_bus_interconnect;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   snd_val = '0;
    logic [N-1:0]   rcv_rdy = '0;
    logic [N*32-1:0] snd_dst = '0;
    logic [N*32-1:0] snd_tag = '0;
    logic [N*64-1:0] snd_msg = '0;

    logic [N-1:0]   ack_a, rval_a, ack_b, rval_b;
    logic [31:0]    src_a, tag_a, src_b, tag_b;
    logic [63:0]    msg_a, msg_b;
    logic [15:0]    drop_a;
    logic [1:0]     drop_b;

    int n_chk  = 0;
    int n_fail = 0;

    xctcmsg_bus_interconnect #(.N_PORTS(N), .DROP_CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .snd_val_i(snd_val), .snd_ack_o(ack_a),
        .snd_dst_i(snd_dst), .snd_tag_i(snd_tag), .snd_msg_i(snd_msg),
        .rcv_rdy_i(rcv_rdy), .rcv_val_o(rval_a), .rcv_src_o(src_a),
        .rcv_tag_o(tag_a), .rcv_msg_o(msg_a), .drop_cnt_o(drop_a)
    );

    xctcmsg_bus_interconnect #(.N_PORTS(N), .DROP_CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .snd_val_i(snd_val), .snd_ack_o(ack_b),
        .snd_dst_i(snd_dst), .snd_tag_i(snd_tag), .snd_msg_i(snd_msg),
        .rcv_rdy_i(rcv_rdy), .rcv_val_o(rval_b), .rcv_src_o(src_b),
        .rcv_tag_o(tag_b), .rcv_msg_o(msg_b), .drop_cnt_o(drop_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: one held message, a rotating priority, a drop tally.
    bit          m_hv = 1'b0;
    int          m_src = 0, m_dst = 0, m_ptr = 0, m_drops = 0;
    logic [31:0] m_tag = '0;
    logic [63:0] m_msg = '0;
    bit          n_hv;
    int          n_src, n_dst, n_ptr, n_drops;
    logic [31:0] n_tag;
    logic [63:0] n_msg;
    int          glog[$];

    always @(negedge clk) begin : model_cmp
        logic [N-1:0] e_ack, e_val;
        int g, d, p;
        if (!rst_n) begin
            chk("rst ack_a", 64'(ack_a), 64'd0);
            chk("rst rval_a", 64'(rval_a), 64'd0);
            chk("rst msg_a", msg_a, 64'd0);
            chk("rst drop_a", 64'(drop_a), 64'd0);
            chk("rst rval_b", 64'(rval_b), 64'd0);
        end else begin
            e_val = m_hv ? N'(1 << m_dst) : '0;
            g = -1;
            if (!m_hv || rcv_rdy[m_dst]) begin
                for (int i = 0; i < N; i++) begin
                    p = (m_ptr + i) % N;
                    if (g < 0 && snd_val[p]) g = p;
                end
            end
            e_ack = (g >= 0) ? N'(1 << g) : '0;
            chk("ack_a", 64'(ack_a), 64'(e_ack));
            chk("ack_b", 64'(ack_b), 64'(e_ack));
            chk("rval_a", 64'(rval_a), 64'(e_val));
            chk("rval_b", 64'(rval_b), 64'(e_val));
            chk("src_a", 64'(src_a), 64'(m_src));
            chk("tag_a", 64'(tag_a), 64'(m_tag));
            chk("msg_a", msg_a, m_msg);
            chk("msg_b", msg_b, m_msg);
            chk("drop_a", 64'(drop_a), 64'((m_drops > 65535) ? 65535 : m_drops));
            chk("drop_b", 64'(drop_b), 64'((m_drops > 3) ? 3 : m_drops));
            n_hv = m_hv; n_src = m_src; n_dst = m_dst; n_tag = m_tag; n_msg = m_msg;
            n_ptr = m_ptr; n_drops = m_drops;
            if (m_hv && rcv_rdy[m_dst]) n_hv = 1'b0;
            if (g >= 0) begin
                glog.push_back(g);
                n_ptr = (g + 1) % N;
                d = int'(snd_dst[32*g +: 32]);
                if (snd_dst[32*g +: 32] < 32'(N)) begin
                    n_hv = 1'b1; n_src = g; n_dst = d;
                    n_tag = snd_tag[32*g +: 32];
                    n_msg = snd_msg[64*g +: 64];
                end else begin
                    n_drops = m_drops + 1;
                end
            end
        end
    end

    always @(posedge clk) begin : model_commit
        if (!rst_n) begin
            m_hv <= 1'b0; m_src <= 0; m_dst <= 0; m_tag <= '0; m_msg <= '0;
            m_ptr <= 0; m_drops <= 0;
        end else begin
            m_hv <= n_hv; m_src <= n_src; m_dst <= n_dst; m_tag <= n_tag;
            m_msg <= n_msg; m_ptr <= n_ptr; m_drops <= n_drops;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    int base;

    initial begin
        for (int i = 0; i < N; i++) begin
            snd_tag[32*i +: 32] = 32'h10 + 32'(i);
            snd_msg[64*i +: 64] = 64'hA000 + 64'(i);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // 1: single send port1 -> port2
        step();
        snd_val = 4'b0010; snd_dst[32*1 +: 32] = 32'd2;
        snd_tag[32*1 +: 32] = 32'h5; snd_msg[64*1 +: 64] = 64'hDEAD; rcv_rdy = 4'b1111;
        #1 chk("t1 ack", 64'(ack_a), 64'h2);
        step(); snd_val = 4'b0000;
        #1 chk("t1 rval", 64'(rval_a), 64'h4);
        chk("t1 src", 64'(src_a), 64'd1);
        chk("t1 tag", 64'(tag_a), 64'h5);
        chk("t1 msg", msg_a, 64'hDEAD);

        // 2: everyone requests to port0, back-to-back grants
        do_reset();
        base = glog.size();
        snd_val = 4'b1111; snd_dst = '0;
        for (int i = 0; i < 8; i++) begin
            #1 chk("t2 ack", 64'(ack_a), 64'(1 << (i % 4)));
            if (i > 0) chk("t2 rval", 64'(rval_a), 64'h1);
            step();
        end
        snd_val = 4'b0000;
        for (int i = 0; i < 8; i++) chk("t2 order", 64'(glog[base+i]), 64'(i % 4));

        // 3: stall on port3 not ready while port2 waits
        do_reset();
        snd_val = 4'b0001; snd_dst[32*0 +: 32] = 32'd3; snd_dst[32*2 +: 32] = 32'd1;
        rcv_rdy = 4'b0111;
        #1 chk("t3 ack0", 64'(ack_a), 64'h1);
        for (int i = 0; i < 5; i++) begin
            step(); snd_val = 4'b0100;
            #1 chk("t3 stall ack", 64'(ack_a), 64'h0);
            chk("t3 stall rval", 64'(rval_a), 64'h8);
        end
        step(); rcv_rdy = 4'b1111;
        #1 chk("t3 rel ack", 64'(ack_a), 64'h4);
        chk("t3 rel rval", 64'(rval_a), 64'h8);
        step(); snd_val = 4'b0000;
        #1 chk("t3 p2 rval", 64'(rval_a), 64'h2);
        chk("t3 p2 src", 64'(src_a), 64'd2);

        // 4: out-of-range destination drops and saturation
        step();
        step(); snd_val = 4'b1000; snd_dst[32*3 +: 32] = 32'd7;
        #1 chk("t4 ack", 64'(ack_a), 64'h8);
        step();
        #1 chk("t4 rval", 64'(rval_a), 64'h0);
        chk("t4 drop1", 64'(drop_a), 64'd1);
        repeat (3) step();
        step(); snd_val = 4'b0000;
        #1 chk("t4 drop16", 64'(drop_a), 64'd5);
        chk("t4 drop2 sat", 64'(drop_b), 64'd3);

        // 5: asynchronous reset while a message is stalled
        step(); snd_val = 4'b0001; snd_dst[32*0 +: 32] = 32'd3; rcv_rdy = 4'b0111;
        #1 chk("t5 ack", 64'(ack_a), 64'h1);
        step(); snd_val = 4'b0000;
        #1 chk("t5 held", 64'(rval_a), 64'h8);
        #1 rst_n = 1'b0; snd_val = 4'b0010;
        #1 chk("t5 async rval", 64'(rval_a), 64'h0);
        chk("t5 async ack", 64'(ack_a), 64'h0);
        chk("t5 async src", 64'(src_a), 64'd0);
        chk("t5 async drop", 64'(drop_a), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1; snd_val = 4'b0000;
        #1 chk("t5 gone", 64'(rval_a), 64'h0);
        step(); snd_val = 4'b1001; snd_dst[32*0 +: 32] = 32'd1; snd_dst[32*3 +: 32] = 32'd1;
        #1 chk("t5 ptr0", 64'(ack_a), 64'h1);

        // 6: self-send on port2
        step(); snd_val = 4'b0100; snd_dst[32*2 +: 32] = 32'd2; rcv_rdy = 4'b1111;
        #1 chk("t6 ack", 64'(ack_a), 64'h4);
        step(); snd_val = 4'b0000;
        #1 chk("t6 rval", 64'(rval_a), 64'h4);
        chk("t6 src", 64'(src_a), 64'd2);
        repeat (2) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
